// File: rtl/prn_shift_seq.sv
// Printhead shift sequencer: DATA_PHASES data groups then one command group, each
// clocked out on a divided SCK and followed by an idle lag. Define PRN_SHIFT_ABORT_EN to enable abort.
module prn_shift_seq #(
  parameter int CH_NUM      = 4,
  parameter int LANE_W      = 4,
  parameter int DATA_PHASES = 2,
  parameter int LAG_TIME    = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [7:0]               head_type,
  input  logic [7:0]               sck_div,
  input  logic                     start_req,
  input  logic                     abort,
  input  logic [CH_NUM*LANE_W-1:0] prn_data,
  input  logic [CH_NUM*LANE_W-1:0] sp_data,
  output logic                     data_req_o,
  output logic                     sp_start,
  output logic                     sp_req,
  output logic [2:0]               phase_idx,
  output logic                     busy,
  output logic                     done,
  output logic [CH_NUM*LANE_W-1:0] f_data,
  output logic                     sck_o
);

  localparam int         W         = CH_NUM * LANE_W;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_D_START = 3'd1;
  localparam logic [2:0] S_D_W     = 3'd2;
  localparam logic [2:0] S_D_LAG   = 3'd3;
  localparam logic [2:0] S_C_START = 3'd4;
  localparam logic [2:0] S_C_W     = 3'd5;
  localparam logic [2:0] S_C_LAG   = 3'd6;
  localparam logic [2:0]  LAST_PH  = 3'(DATA_PHASES - 1);
  localparam logic [15:0] LAG_END  = 16'(LAG_TIME);

  // Upper byte is the data depth, lower byte the command count; unknown codes keep the old pair.
  function automatic logic [15:0] decode_cnt(input logic [7:0] ht, input logic [15:0] hold);
    logic [15:0] r;
    case (ht)
      8'h02, 8'h03, 8'h04, 8'h05: r = {8'd90, 8'd16};
      8'h01, 8'h06:               r = {8'd100, 8'd8};
      default:                    r = hold;
    endcase
    return r;
  endfunction

  logic [2:0]   state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [7:0]   n_q, n_d;
  logic [7:0]   div_q, div_d;
  logic [7:0]   bit_q, bit_d;
  logic         sck_q, sck_d;
  logic [15:0]  lag_q, lag_d;
  logic [2:0]   phase_q, phase_d;
  logic         data_req_q, data_req_d;
  logic         sp_req_q, sp_req_d;
  logic         sp_start_q, sp_start_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         sck_o_q, sck_o_d;
  logic [W-1:0] f_data_q, f_data_d;
  logic         req_s;
  logic         w_next_s;
  logic         abort_now_s;

`ifdef PRN_SHIFT_ABORT_EN
  // C_LAG is already the abort destination, so a held abort there just lets the lag run out.
  assign abort_now_s = abort && (state_q != S_IDLE) && (state_q != S_C_LAG);
`else
  logic abort_unused_s;
  assign abort_unused_s = abort;
  assign abort_now_s    = 1'b0;
`endif

  // Sequencer state, SCK divider, lag counter and request events.
  always_comb begin
    cnt_d   = decode_cnt(head_type, cnt_q);
    state_d = state_q;
    n_d     = n_q;
    div_d   = 8'd0;
    bit_d   = 8'd0;
    sck_d   = 1'b0;
    lag_d   = 16'd0;
    phase_d = phase_q;
    req_s   = 1'b0;
    if (abort_now_s) begin
      state_d = S_C_LAG;
    end else begin
      case (state_q)
        S_IDLE: begin
          phase_d = 3'd0;
          state_d = start_req ? S_D_START : S_IDLE;
        end
        S_D_START: begin
          n_d     = cnt_d[15:8];
          req_s   = (n_d != 8'd0);
          state_d = S_D_W;
        end
        S_C_START: begin
          n_d     = cnt_d[7:0];
          req_s   = (n_d != 8'd0);
          state_d = S_C_W;
        end
        S_D_W, S_C_W: begin
          div_d = div_q;
          bit_d = bit_q;
          sck_d = sck_q;
          if (n_q == 8'd0) begin
            state_d = (state_q == S_D_W) ? S_D_LAG : S_C_LAG;
          end else if (div_q == sck_div) begin
            div_d = 8'd0;
            sck_d = ~sck_q;
            // Rising edge counts a bit; falling edge either ends the group or asks for the next word.
            if (!sck_q) begin
              bit_d = bit_q + 8'd1;
            end else if (bit_q == n_q) begin
              state_d = (state_q == S_D_W) ? S_D_LAG : S_C_LAG;
            end else begin
              req_s = 1'b1;
            end
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        S_D_LAG: begin
          lag_d = lag_q + 16'd1;
          if (lag_q == LAG_END) begin
            lag_d = 16'd0;
            if (phase_q < LAST_PH) begin
              phase_d = phase_q + 3'd1;
              state_d = S_D_START;
            end else begin
              state_d = S_C_START;
            end
          end else begin
            state_d = S_D_LAG;
          end
        end
        S_C_LAG: begin
          lag_d = lag_q + 16'd1;
          if (lag_q == LAG_END) begin
            lag_d   = 16'd0;
            state_d = S_IDLE;
          end else begin
            state_d = S_C_LAG;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    w_next_s   = (state_d == S_D_W) || (state_d == S_C_W);
    data_req_d = req_s && ((state_q == S_D_START) || (state_q == S_D_W));
    sp_req_d   = req_s && ((state_q == S_C_START) || (state_q == S_C_W));
    sp_start_d = (state_d == S_C_START);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q == S_C_LAG) && (state_d == S_IDLE);
    sck_o_d    = w_next_s && sck_d;
    if (state_d == S_IDLE) begin
      f_data_d = '0;
    end else if (data_req_q) begin
      f_data_d = prn_data;
    end else if (sp_req_q) begin
      f_data_d = sp_data;
    end else begin
      f_data_d = f_data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= {8'd90, 8'd16};
      n_q        <= 8'd0;
      div_q      <= 8'd0;
      bit_q      <= 8'd0;
      sck_q      <= 1'b0;
      lag_q      <= 16'd0;
      phase_q    <= 3'd0;
      data_req_q <= 1'b0;
      sp_req_q   <= 1'b0;
      sp_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sck_o_q    <= 1'b0;
      f_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sck_q      <= sck_d;
      lag_q      <= lag_d;
      phase_q    <= phase_d;
      data_req_q <= data_req_d;
      sp_req_q   <= sp_req_d;
      sp_start_q <= sp_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sck_o_q    <= sck_o_d;
      f_data_q   <= f_data_d;
    end
  end

  assign data_req_o = data_req_q;
  assign sp_req     = sp_req_q;
  assign sp_start   = sp_start_q;
  assign phase_idx  = phase_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sck_o      = sck_o_q;
  assign f_data     = f_data_q;

endmodule

// File: tb/tb_prn_shift_seq.sv
// Self-checking bench for prn_shift_seq: per-sequence trace statistics compared with
// counts and durations derived from the head-type table, divider and lag length.
module tb_prn_shift_seq;

  localparam int W   = 16;
  localparam int DP  = 3;
  localparam int LAG = 16;

  logic         clk;
  logic         rstn;
  logic [7:0]   head_type;
  logic [7:0]   sck_div;
  logic         start_req;
  logic         abort;
  logic [W-1:0] prn_data;
  logic [W-1:0] sp_data;
  logic         data_req_o;
  logic         sp_start;
  logic         sp_req;
  logic [2:0]   phase_idx;
  logic         busy;
  logic         done;
  logic [W-1:0] f_data;
  logic         sck_o;

  prn_shift_seq #(
    .CH_NUM(4), .LANE_W(4), .DATA_PHASES(DP), .LAG_TIME(LAG)
  ) dut (
    .clk(clk), .rstn(rstn), .head_type(head_type), .sck_div(sck_div),
    .start_req(start_req), .abort(abort), .prn_data(prn_data), .sp_data(sp_data),
    .data_req_o(data_req_o), .sp_start(sp_start), .sp_req(sp_req),
    .phase_idx(phase_idx), .busy(busy), .done(done), .f_data(f_data), .sck_o(sck_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int npass, nchk, nfail;
  int m_depth, m_cmd;
  int cyc, creq, cpul, cfirst, clast, nstart, ndone, nbusy, start_cyc, done_cyc;
  int fbad, obad, ph_bad, ph_prev, post_req, post_sck;
  int dreq[DP], dpul[DP], dfirst[DP], dlast[DP];
  bit in_cmd, pend;
  logic prev_sck;
  logic [W-1:0] pend_val;

  task automatic chk(input string tag, input longint obs, input longint exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference head-type table: known codes set depth/count, others keep the previous pair.
  task automatic set_head(input logic [7:0] ht);
    head_type = ht;
    if (ht >= 8'h02 && ht <= 8'h05) begin
      m_depth = 90; m_cmd = 16;
    end else if (ht == 8'h01 || ht == 8'h06) begin
      m_depth = 100; m_cmd = 8;
    end
  endtask

  task automatic clear_stats();
    for (int p = 0; p < DP; p++) begin
      dreq[p] = 0; dpul[p] = 0; dfirst[p] = 0; dlast[p] = 0;
    end
    creq = 0; cpul = 0; cfirst = 0; clast = 0; nstart = 0; ndone = 0; nbusy = 0;
    start_cyc = 0; done_cyc = 0; fbad = 0; obad = 0; ph_bad = 0; ph_prev = 0;
    post_req = 0; post_sck = 0; in_cmd = 0; pend = 0; prev_sck = 1'b0;
  endtask

  task automatic step();
    int ph;
    @(negedge clk);
    cyc++;
    ph = int'(phase_idx);
    if (pend && f_data !== pend_val) fbad++;
    if (!busy && f_data !== '0) fbad++;
    if (!busy && (data_req_o || sp_req || sck_o || sp_start)) obad++;
    if (data_req_o && sp_req) obad++;
    if (sp_start) begin nstart++; in_cmd = 1; start_cyc = cyc; end
    if (data_req_o) begin
      if (in_cmd) obad++;
      if (abort) post_req++;
      if (ph < DP) begin
        if (dreq[ph] == 0) dfirst[ph] = cyc;
        dreq[ph]++;
      end else obad++;
    end
    if (sp_req) begin
      if (!in_cmd) obad++;
      if (abort) post_req++;
      if (creq == 0) cfirst = cyc;
      creq++;
    end
    if (sck_o) begin
      if (abort) post_sck++;
      if (in_cmd) begin
        if (!prev_sck) cpul++;
        clast = cyc;
      end else if (ph < DP) begin
        if (!prev_sck) dpul[ph]++;
        dlast[ph] = cyc;
      end else obad++;
    end
    prev_sck = sck_o;
    if (busy) begin
      nbusy++;
      if (!in_cmd) begin
        if (ph < ph_prev || ph > ph_prev + 1) ph_bad++;
        ph_prev = ph;
      end else if (ph != ph_prev) ph_bad++;
    end
    if (done) begin ndone++; done_cyc = cyc; end
    pend     = data_req_o || sp_req;
    prn_data = W'($urandom);
    sp_data  = W'($urandom);
    pend_val = data_req_o ? prn_data : sp_data;
  endtask

  task automatic run_seq(input string nm, input logic [7:0] ht0, input logic [7:0] div,
                         input int chg_at, input logic [7:0] ht_new, input int abort_at,
                         input bit keep_start);
    int n_ph[DP];
    int n_c, exp_busy, guard, abort_cyc, half;
    bit chg_done, aborting;
    clear_stats();
    set_head(ht0);
    sck_div   = div;
    start_req = 1'b1;
    half      = int'(div) + 1;
    for (int p = 0; p < DP; p++) n_ph[p] = m_depth;
    n_c = m_cmd;
    abort_cyc = -1; chg_done = 0; guard = 0;
    step();
    start_req = keep_start;
    chk({nm, "_busy_first"}, busy, 1);
    while (ndone == 0 && guard < 6000) begin
      step();
      guard++;
      if (chg_at >= 0 && !chg_done && dreq[0] == chg_at) begin
        set_head(ht_new);
        for (int p = 1; p < DP; p++) n_ph[p] = m_depth;
        n_c = m_cmd;
        chg_done = 1;
      end
      if (abort_at > 0 && abort_cyc < 0 && dreq[0] == abort_at) begin
        abort = 1'b1;
        abort_cyc = cyc;
      end
    end
    chk({nm, "_done"}, ndone, 1);
    chk({nm, "_busy_at_done"}, busy, 0);
    chk({nm, "_fdata"}, fbad, 0);
    chk({nm, "_order"}, obad, 0);
    aborting = (abort_at > 0);
`ifndef PRN_SHIFT_ABORT_EN
    aborting = 0;
`endif
    if (aborting) begin
      chk({nm, "_dreq_at_abort"}, dreq[0], abort_at);
      chk({nm, "_req_after_abort"}, post_req, 0);
      chk({nm, "_sck_after_abort"}, post_sck, 0);
      chk({nm, "_no_sp_start"}, nstart, 0);
      chk({nm, "_abort_to_done"}, done_cyc - abort_cyc, LAG + 2);
    end else begin
      exp_busy = DP * (LAG + 2) + (LAG + 2) + 2 * n_c * half;
      for (int p = 0; p < DP; p++) begin
        exp_busy += 2 * n_ph[p] * half;
        chk($sformatf("%s_dreq%0d", nm, p), dreq[p], n_ph[p]);
        chk($sformatf("%s_dsck%0d", nm, p), dpul[p], n_ph[p]);
        chk($sformatf("%s_dwlen%0d", nm, p), dlast[p] - dfirst[p] + 1, 2 * n_ph[p] * half);
        if (p > 0) chk($sformatf("%s_gap%0d", nm, p), dfirst[p] - dlast[p-1] - 1, LAG + 2);
      end
      chk({nm, "_spreq"}, creq, n_c);
      chk({nm, "_csck"}, cpul, n_c);
      chk({nm, "_cwlen"}, clast - cfirst + 1, 2 * n_c * half);
      chk({nm, "_dlag"}, start_cyc - dlast[DP-1] - 1, LAG + 1);
      chk({nm, "_clag"}, done_cyc - clast - 1, LAG + 1);
      chk({nm, "_sp_start"}, nstart, 1);
      chk({nm, "_busy_len"}, nbusy, exp_busy);
      chk({nm, "_phase_walk"}, ph_bad, 0);
      chk({nm, "_phase_last"}, ph_prev, DP - 1);
    end
    abort = 1'b0;
  endtask

  initial begin
    int guard, k;
    npass = 0; nchk = 0; nfail = 0; cyc = 0;
    m_depth = 90; m_cmd = 16;
    rstn = 1'b1; head_type = 8'h00; sck_div = 8'd0; start_req = 1'b0; abort = 1'b0;
    prn_data = '0; sp_data = '0;
    clear_stats();
    #2 rstn = 1'b0;
    #1;
    chk("reset_outputs", {data_req_o, sp_start, sp_req, phase_idx, busy, done, sck_o, f_data}, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    run_seq("ht02_div1", 8'h02, 8'd1, -1, 8'h00, 0, 0);
    run_seq("ht06_div0", 8'h06, 8'd0, -1, 8'h00, 0, 0);
    run_seq("ht_change", 8'h02, 8'd0, 20, 8'h01, 0, 0);
    run_seq("hold_start_a", 8'h03, 8'd0, -1, 8'h00, 0, 1);
    run_seq("hold_start_b", 8'h03, 8'd0, -1, 8'h00, 0, 0);
    run_seq("abort40", 8'h02, 8'd0, -1, 8'h00, 40, 0);
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(0, 6);
      run_seq($sformatf("rnd%0d", i), (k == 0) ? 8'h7f : 8'(k), 8'($urandom_range(0, 2)),
              -1, 8'h00, 0, 0);
    end

    // Reset in the middle of the command group, then a full run on the reset defaults.
    clear_stats();
    set_head(8'h01);
    sck_div = 8'd0;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    guard = 0;
    while (nstart == 0 && guard < 6000) begin step(); guard++; end
    repeat (6) step();
    chk("pre_rst_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_outputs", {data_req_o, sp_start, sp_req, phase_idx, busy, done, sck_o, f_data}, 0);
    m_depth = 90; m_cmd = 16;
    set_head(8'h00);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    clear_stats();
    step();
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_quiet", obad, 0);
    run_seq("post_rst", 8'h00, 8'd1, -1, 8'h00, 0, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
